scan_chain_ctrl: RTL

- Sequences one scan chain of set-able scan flip-flops, i.e. cells with SE, SI, D, CLK, active-low SETN and Q.
- Per test: async-presets the chain, shifts a pattern in, applies one functional capture clock, shifts the chain out and presents the unloaded word.
- Sits between a BIST/test-access register block and the chain's SE/SI/SETN pins; chain SO returns to this block.

---
 rtl/scan_chain_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: preset, shift-in, one capture clock, shift-out, present the word.
// Optional compare of the unloaded word against a latched expectation: SCAN_CHAIN_CTRL_COMPARE_EN.
module scan_chain_ctrl #(
    parameter int unsigned CHAIN_LEN = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [CHAIN_LEN-1:0] PATTERN,
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    input  logic [CHAIN_LEN-1:0] EXPECT,
    output logic                 MISMATCH,
`endif
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 SETN_OUT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESULT
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPreset,
        StShift,
        StCapture,
        StUnload,
        StFin
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CHAIN_LEN-1:0] r_pat;
    logic [CHAIN_LEN-1:0] r_res;
    logic [CHAIN_LEN-1:0] r_result;
    logic                 r_se;
    logic                 r_si;
    logic                 r_setn;
    logic                 r_busy;
    logic                 r_done;

    logic [CNT_W-1:0]     w_cnt_inc;
    logic [CNT_W-1:0]     w_si_idx;
    logic [CHAIN_LEN-1:0] w_res_nxt;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_si_idx  = LAST - w_cnt_inc;

    // Capture word including the bit sampled at this edge, so RESULT is complete while DONE is high.
    always_comb begin
        w_res_nxt                = r_res;
        w_res_nxt[LAST - r_cnt]  = SO;
    end

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] r_exp;
    logic                 r_mis;
    assign MISMATCH = r_mis;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_exp <= '0;
            r_mis <= 1'b0;
        end else if (r_state == StIdle && START) begin
            r_exp <= EXPECT;
            r_mis <= 1'b0;
        end else if (r_state == StUnload && r_cnt == LAST) begin
            r_mis <= (w_res_nxt != r_exp);
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_pat    <= '0;
            r_res    <= '0;
            r_result <= '0;
            r_se     <= 1'b0;
            r_si     <= 1'b0;
            r_setn   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (START) begin
                        r_pat   <= PATTERN;
                        r_state <= StPreset;
                        r_setn  <= 1'b0;
                        r_se    <= 1'b0;
                        r_si    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                StPreset: begin
                    r_state <= StShift;
                    r_setn  <= 1'b1;
                    r_se    <= 1'b1;
                    r_si    <= r_pat[LAST];
                    r_cnt   <= '0;
                end
                StShift: begin
                    if (r_cnt == LAST) begin
                        r_state <= StCapture;
                        r_se    <= 1'b0;
                        r_si    <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        r_si  <= r_pat[w_si_idx];
                    end
                end
                StCapture: begin
                    r_state <= StUnload;
                    r_se    <= 1'b1;
                    r_si    <= 1'b0;
                    r_cnt   <= '0;
                end
                StUnload: begin
                    r_res <= w_res_nxt;
                    if (r_cnt == LAST) begin
                        r_state  <= StFin;
                        r_se     <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_res_nxt;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                StFin: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign SE       = r_se;
    assign SI       = r_si;
    assign SETN_OUT = r_setn;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign RESULT   = r_result;

endmodule
